ringfifo: RTL and testbench
===========================

# ringfifo

Parallel client port for a ring node, the on-chip alternative to the SPI client port. Sits directly on a ringnode's client side: it accepts addressed payloads from a synchronous client into a transmit FIFO and launches them into the node over the toggle handshake, and it drains received packets from the node into a receive FIFO for the client. Everything runs in the ring `clk` domain and uses valid/ready on the client side.

## Interface
- `WIDTH`, 16: ring packet width.
- `ABITS`, 3: node address width.
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- PBITS (derived) = WIDTH-2-2*ABITS: payload width, 8 at defaults.
- Packet field layout:
  - FULL = bit WIDTH-1; ACK = bit WIDTH-2.
  - DST = [WIDTH-2-ABITS +: ABITS]; SRC = [WIDTH-2-2*ABITS +: ABITS].
  - Payload = [PBITS-1:0].

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_valid`  in  1  client offers a payload.
- `tx_ready`  out  1  tx FIFO not full.
- `tx_dst`  in  ABITS  destination node address.
- `tx_data`  in  PBITS  payload.
- `rx_valid`  out  1  rx FIFO not empty.
- `rx_ready`  in  1  client consumes the rx head.
- `rx_src`  out  ABITS  source address of the rx head.
- `rx_data`  out  PBITS  payload of the rx head.
- `txdata`  out  WIDTH  packet presented to the node (node's `fromclient`).
- `mosivalid`  out  1  tx toggle request.
- `mosiack`  in  1  tx toggle acknowledge from the node.
- `txready`  in  1  node transmit buffer empty.
- `rxdata`  in  WIDTH  node receive buffer (node's `toclient`).
- `misovalid`  in  1  rx toggle request from the node.
- `misoack`  out  1  rx toggle acknowledge.

## Operation
- Two independent circular FIFOs, each with DEPTH entries.
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy counter is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- Tx FIFO:
  - Pushes on `tx_valid & tx_ready`.
  - Each entry stores {tx_dst, tx_data}.
  - `tx_ready` = ~full.
- Tx launch happens when the tx FIFO is non-empty AND `mosivalid==mosiack` AND `txready`. At that edge:
  - `txdata` <= {1'b1, 1'b0, dst, {ABITS{0}}, payload}. SRC is zeroed because the node inserts its own address.
  - `mosivalid` toggles.
  - The tx FIFO pops.
- `txdata` holds until the next launch. Launching without `txready` is forbidden because the node would overwrite an unsent packet.
- Rx capture happens when `misovalid != misoack` AND the rx FIFO is not full. At that edge:
  - The rx FIFO pushes {rxdata SRC field, rxdata payload}.
  - `misoack` toggles.
- If the rx FIFO is full, the ack is withheld. The node's receive buffer stays occupied and the ring retries; nothing is dropped.
- Rx FIFO:
  - Pops on `rx_valid & rx_ready`.
  - `rx_valid` = ~empty; `rx_src` and `rx_data` show the head entry.
- Simultaneous push and pop on the same FIFO:
  - The count is unchanged.
  - A push is allowed only when the count, registered before the edge, is below DEPTH, so a pop does not free space in the same cycle.
  - A pop is allowed when the count is 1 or more, so a push into an empty FIFO is not bypassed to the output.

## Timing
- Reset values:
  - `tx_ready`=1, `rx_valid`=0, `rx_src`=0, `rx_data`=0.
  - `txdata`=0, `mosivalid`=0, `misoack`=0.
  - Pointers and counts = 0.
  - Toggle levels match the node's reset levels. The node and this block share `rst`; a reset mid-transfer discards FIFO contents and leaves the handshakes idle.
- Tx path latency:
  - Push at edge E; the earliest launch is at E+1.
  - The node's 2-flop synchroniser toggles `mosiack` and drops `txready` at E+3.
  - The next launch waits for `txready` to rise again, after the ring ack returns.
- Rx path latency:
  - `misovalid` toggles at edge R; capture and the `misoack` toggle happen at R+1.
  - `rx_valid` is high after R+1.
  - The node clears its buffer at R+3.
- All outputs are registered or decoded from registered counts. There is no combinational path from `tx_valid`/`rx_ready` to outputs other than through FIFO state.

## Test plan
- Reset, then push dst=5, data=0xA7 from node 2.
  - At the launch edge: `txdata`=0xA8A7 and `mosivalid` goes 0→1.
  - The launch does not occur until `txready`=1.
- Push 4 words with `txready` held low.
  - `tx_ready` goes low after the 4th push; a 5th `tx_valid` is not accepted.
  - Raise `txready` and toggle `mosiack` per launch: words launch in FIFO order, with pointer wrap exercised.
- Hold `rx_ready`=0 and toggle `misovalid` 5 times, with `rxdata` SRC=3 and payloads 0x10..0x14, toggling each time only after `misoack` answers.
  - 4 words are captured.
  - The 5th `misoack` toggle is withheld until one pop, then it occurs with payload 0x14.
- Full rx FIFO with `rx_ready`=1 and a pending `misovalid`, all in the same cycle.
  - Pop only; the push lands on the next edge; the count returns to 4.
- Empty rx FIFO with a capture and `rx_ready`=1 in the same cycle.
  - `rx_valid` stays 0 that cycle; no pop occurs.
- Assert `rst` with both FIFOs partly full and `mosivalid`≠`mosiack`.
  - All outputs return to their reset values immediately; there are no launches afterwards until a new push.

Source files
------------

// File: rtl/ringfifo.sv
// rtl/ringfifo.sv - parallel ring-node client port: tx/rx FIFOs over toggle handshakes
module ringfifo_q #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Both qualifiers use the pre-edge count: no same-cycle space reuse, no empty bypass.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ringfifo #(
  parameter int WIDTH = 16,
  parameter int ABITS = 3,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [ABITS-1:0]              tx_dst,
  input  logic [WIDTH-2-2*ABITS-1:0]    tx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [ABITS-1:0]              rx_src,
  output logic [WIDTH-2-2*ABITS-1:0]    rx_data,
  output logic [WIDTH-1:0]              txdata,
  output logic                          mosivalid,
  input  logic                          mosiack,
  input  logic                          txready,
  input  logic [WIDTH-1:0]              rxdata,
  input  logic                          misovalid,
  output logic                          misoack
);
  localparam int PBITS = WIDTH - 2 - 2 * ABITS;
  localparam int QW    = ABITS + PBITS;

  logic [QW-1:0] tx_head;
  logic [QW-1:0] rx_head;
  logic          tx_full, tx_empty;
  logic          rx_full, rx_empty;
  logic          tx_launch;
  logic          rx_cap;
  logic          unused_rx_hdr;

  // Launch only into an empty node buffer with no toggle outstanding.
  assign tx_launch = ~tx_empty & (mosivalid == mosiack) & txready;
  assign rx_cap    = (misovalid != misoack) & ~rx_full;

  ringfifo_q #(.W(QW), .DEPTH(DEPTH)) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .wdata ({tx_dst, tx_data}),
    .pop   (tx_launch),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  ringfifo_q #(.W(QW), .DEPTH(DEPTH)) u_rxq (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_cap),
    .wdata ({rxdata[PBITS +: ABITS], rxdata[PBITS-1:0]}),
    .pop   (rx_ready),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_ready          = ~tx_full;
  assign rx_valid          = ~rx_empty;
  assign {rx_src, rx_data} = rx_head;
  assign unused_rx_hdr     = ^rxdata[WIDTH-1:PBITS+ABITS];

  // SRC goes out as zero; the node stamps its own address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txdata    <= '0;
      mosivalid <= 1'b0;
      misoack   <= 1'b0;
    end else begin
      if (tx_launch) begin
        txdata    <= {1'b1, 1'b0, tx_head[QW-1 -: ABITS], {ABITS{1'b0}}, tx_head[PBITS-1:0]};
        mosivalid <= ~mosivalid;
      end
      if (rx_cap) misoack <= ~misoack;
    end
  end
endmodule

// File: tb/tb_ringfifo.sv
// tb/tb_ringfifo.sv - scoreboard bench for ringfifo
module tb_ringfifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [2:0]  tx_dst = '0;
  logic [7:0]  tx_data = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  rx_src;
  logic [7:0]  rx_data;
  logic [15:0] txdata;
  logic        mosivalid;
  logic        mosiack = 1'b0;
  logic        txready = 1'b0;
  logic [15:0] rxdata = '0;
  logic        misovalid = 1'b0;
  logic        misoack;

  int n_vec = 0;
  int n_bad = 0;
  int rx_pops = 0;
  logic prev_mv = 1'b0;
  logic [15:0] tx_exp[$];
  logic [10:0] rx_exp[$];

  ringfifo dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_data(rx_data),
    .txdata(txdata), .mosivalid(mosivalid), .mosiack(mosiack), .txready(txready),
    .rxdata(rxdata), .misovalid(misovalid), .misoack(misoack)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // tx monitor: every mosivalid toggle is a launch to score
  always @(negedge clk) begin
    if (!rst && mosivalid != prev_mv) begin
      if (tx_exp.size() == 0) check("tx_unexpected_launch", {16'h0, txdata}, 32'hFFFF_FFFF);
      else check("txdata", {16'h0, txdata}, {16'h0, tx_exp.pop_front()});
    end
    prev_mv = mosivalid;
  end

  // rx monitor: score the head whenever the client consumes it
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      rx_pops++;
      if (rx_exp.size() == 0) check("rx_unexpected_pop", {21'h0, rx_src, rx_data}, 32'hFFFF_FFFF);
      else check("rx_head", {21'h0, rx_src, rx_data}, {21'h0, rx_exp.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [2:0] d, input logic [7:0] p);
    tx_valid = 1'b1; tx_dst = d; tx_data = p;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_launch();
    for (int k = 0; k < 10; k++) begin
      if (mosivalid != mosiack) break;
      step();
    end
    check("launch_seen", {31'h0, mosivalid != mosiack}, 1);
  endtask

  task automatic node_ack();
    txready = 1'b0;
    mosiack = mosivalid;
    step();
  endtask

  task automatic rx_offer(input logic [15:0] pkt);
    rxdata = pkt;
    misovalid = ~misovalid;
  endtask

  task automatic wait_rx_ack();
    for (int k = 0; k < 8; k++) begin
      if (misoack == misovalid) break;
      step();
    end
    check("rx_ack", {31'h0, misoack}, {31'h0, misovalid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    check("rst_tx_ready", {31'h0, tx_ready}, 1);
    check("rst_rx_valid", {31'h0, rx_valid}, 0);
    check("rst_rx_head", {21'h0, rx_src, rx_data}, 0);
    check("rst_txdata", {16'h0, txdata}, 0);
    check("rst_toggles", {30'h0, mosivalid, misoack}, 0);
    rst = 1'b0;
    step();

    // single launch gated by txready
    tx_exp.push_back(16'hA8A7);
    push_tx(3'd5, 8'hA7);
    step(); step(); step();
    check("no_launch_wo_txready", {31'h0, mosivalid}, 0);
    txready = 1'b1;
    wait_launch();
    check("mosivalid_rose", {31'h0, mosivalid}, 1);
    node_ack();

    // fill tx FIFO with txready low, then drain in order across the wrap
    tx_exp.push_back(16'h8811); push_tx(3'd1, 8'h11);
    check("tx_ready_1", {31'h0, tx_ready}, 1);
    tx_exp.push_back(16'h9022); push_tx(3'd2, 8'h22);
    check("tx_ready_2", {31'h0, tx_ready}, 1);
    tx_exp.push_back(16'h9833); push_tx(3'd3, 8'h33);
    check("tx_ready_3", {31'h0, tx_ready}, 1);
    tx_exp.push_back(16'hB844); push_tx(3'd7, 8'h44);
    check("tx_ready_full", {31'h0, tx_ready}, 0);
    push_tx(3'd6, 8'h55);
    check("tx_fifth_refused", {31'h0, tx_ready}, 0);
    for (int i = 0; i < 4; i++) begin
      txready = 1'b1;
      wait_launch();
      node_ack();
    end
    check("tx_ready_after_drain", {31'h0, tx_ready}, 1);
    check("tx_queue_drained", tx_exp.size(), 0);

    // rx: five offers into a four-entry FIFO with the client stalled
    for (int i = 0; i < 5; i++) begin
      rx_exp.push_back({3'd3, 8'h10 + 8'(i)});
      rx_offer(16'h9310 + 16'(i));
      if (i < 4) wait_rx_ack();
    end
    step(); step(); step(); step(); step();
    check("rx_ack_withheld", {31'h0, misoack == misovalid}, 0);
    check("rx_valid_full", {31'h0, rx_valid}, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("rx_no_same_edge_push", {31'h0, misoack == misovalid}, 0);
    step();
    check("rx_late_capture", {31'h0, misoack == misovalid}, 1);
    rx_pops = 0;
    rx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!rx_valid) break;
    end
    check("rx_drain_count", rx_pops, 4);

    // capture into empty FIFO with client ready: no bypass
    rx_exp.push_back({3'd6, 8'h55});
    rx_offer(16'h9655);
    #1;
    check("rx_valid_empty_cycle", {31'h0, rx_valid}, 0);
    step();
    check("rx_valid_after_cap", {31'h0, rx_valid}, 1);
    step();
    check("rx_valid_after_pop", {31'h0, rx_valid}, 0);
    check("rx_queue_drained", rx_exp.size(), 0);
    rx_ready = 1'b0;

    // reset mid-transfer with both FIFOs holding data
    txready = 1'b1;
    tx_exp.push_back(16'h983C);
    push_tx(3'd3, 8'h3C);
    wait_launch();
    push_tx(3'd1, 8'h01);
    push_tx(3'd1, 8'h02);
    rx_offer(16'h9301); wait_rx_ack();
    rx_offer(16'h9302); wait_rx_ack();
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_ready", {31'h0, tx_ready}, 1);
    check("arst_rx_valid", {31'h0, rx_valid}, 0);
    check("arst_rx_head", {21'h0, rx_src, rx_data}, 0);
    check("arst_txdata", {16'h0, txdata}, 0);
    check("arst_toggles", {30'h0, mosivalid, misoack}, 0);
    mosiack = 1'b0; misovalid = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("no_launch_after_rst", {31'h0, mosivalid}, 0);
    check("rx_empty_after_rst", {31'h0, rx_valid}, 0);

    tx_exp.push_back(16'hA099);
    push_tx(3'd4, 8'h99);
    wait_launch();
    node_ack();
    step(); step();
    check("tx_queue_final", tx_exp.size(), 0);
    check("rx_queue_final", rx_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
